// File: rtl/ffo_scan_iter_if.sv
// Load/emit handshake bundle for ffo_scan_iter.
// Bit 0 of load_vec is the leftmost and first in scan order.
interface ffo_scan_iter_if #(
  parameter int unsigned N = 32
);
  localparam int unsigned P = $clog2(N);

  logic         load_valid;
  logic         load_ready;
  logic [0:N-1] load_vec;
  logic [0:P-1] load_start;
  logic         out_valid;
  logic         out_ready;
  logic [0:P-1] out_pos;
  logic         out_last;
  logic         zero_load;
  logic         busy;

  modport master (
    output load_valid, load_vec, load_start, out_ready,
    input  load_ready, out_valid, out_pos, out_last, zero_load, busy
  );

  modport slave (
    input  load_valid, load_vec, load_start, out_ready,
    output load_ready, out_valid, out_pos, out_last, zero_load, busy
  );
endinterface

// File: rtl/ffo_scan_iter.sv
// Sequential find-first-one: emits every set bit of a loaded vector, one per handshake,
// in circular order starting at the load's start index.
module ffo_scan_iter #(
  parameter int unsigned N = 32
) (
  input  logic          clk,
  input  logic          reset,
  ffo_scan_iter_if.slave bus
);
  localparam int unsigned P = $clog2(N);

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  state_e       state_q, state_d;
  logic [0:N-1] mask_q, mask_d;
  logic [0:P-1] ptr_q, ptr_d;
  logic         zero_q, zero_d;

  logic         hi_found, lo_found;
  logic [0:P-1] hi_pos, lo_pos, scan_pos;
  logic [0:N-1] mask_clr;
  logic         scan_last;
  logic         out_valid;
  logic         fire;
  logic         load_fire;

  // Descending walk so the lowest qualifying index is the one that sticks.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_pos   = '0;
    lo_pos   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        lo_found = 1'b1;
        lo_pos   = P'(i);
        if (P'(i) >= ptr_q) begin
          hi_found = 1'b1;
          hi_pos   = P'(i);
        end
      end
    end
    scan_pos           = hi_found ? hi_pos : lo_pos;
    mask_clr           = mask_q;
    mask_clr[scan_pos] = 1'b0;
    scan_last          = lo_found && (mask_clr == '0);
  end

  assign out_valid      = (state_q == StScan) && !reset;
  assign fire           = out_valid && bus.out_ready;
  assign load_fire      = bus.load_valid && bus.load_ready;

  assign bus.load_ready = (state_q == StIdle) && !reset;
  assign bus.out_valid  = out_valid;
  assign bus.out_pos    = out_valid ? scan_pos : '0;
  assign bus.out_last   = out_valid && scan_last;
  assign bus.zero_load  = zero_q;
  assign bus.busy       = out_valid;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    ptr_d   = ptr_q;
    zero_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load_fire) begin
          if (bus.load_vec == '0) begin
            zero_d = 1'b1;
          end else begin
            mask_d  = bus.load_vec;
            // Out-of-range start indices (only possible for non-power-of-two N) fold to 0.
            ptr_d   = (32'(bus.load_start) < N) ? bus.load_start : '0;
            state_d = StScan;
          end
        end
      end
      StScan: begin
        if (fire) begin
          mask_d = mask_clr;
          ptr_d  = (32'(scan_pos) == N - 1) ? '0 : scan_pos + 1'b1;
          if (scan_last) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      mask_q  <= '0;
      ptr_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      ptr_q   <= ptr_d;
      zero_q  <= zero_d;
    end
  end
endmodule

// File: tb/tb_ffo_scan_iter.sv
// Scoreboard bench: loads push expected positions, a negedge monitor pops and compares.
module tb_ffo_scan_iter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ffo_scan_iter_if #(.N(32)) bus ();
  ffo_scan_iter_if #(.N(5))  bus5 ();

  ffo_scan_iter #(.N(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  ffo_scan_iter #(.N(5))  dut5 (.clk(clk), .reset(reset), .bus(bus5));

  typedef struct {
    int pos;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   pops = 0;
  bit   exp_zero = 1'b0;
  int   rdy_mode = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Reference: walk the ring from the (folded) start, collecting set bits.
  function automatic void push_model(logic [0:31] vec, int start);
    int   s;
    int   cnt;
    int   seen;
    int   idx;
    exp_t e;
    s    = (start >= 32) ? 0 : start;
    cnt  = $countones(vec);
    seen = 0;
    for (int k = 0; k < 32; k++) begin
      idx = (s + k) % 32;
      if (vec[idx]) begin
        seen++;
        e.pos  = idx;
        e.last = (seen == cnt);
        exp_q.push_back(e);
      end
    end
  endfunction

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ~bus.out_ready;
      default: bus.out_ready = 1'($urandom % 2);
    endcase
  end

  always @(negedge clk) begin
    bit exp_busy;
    if (reset) begin
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_load_ready", int'(bus.load_ready), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_out_pos", int'(bus.out_pos), 0);
    end else begin
      exp_busy = (exp_q.size() != 0);
      chk("zero_load", int'(bus.zero_load), int'(exp_zero));
      exp_zero = 1'b0;
      chk("out_valid", int'(bus.out_valid), int'(exp_busy));
      chk("busy", int'(bus.busy), int'(exp_busy));
      chk("load_ready", int'(bus.load_ready), int'(!exp_busy));
      if (bus.out_valid && exp_busy) begin
        chk("out_pos", int'(bus.out_pos), exp_q[0].pos);
        chk("out_last", int'(bus.out_last), int'(exp_q[0].last));
        if (bus.out_ready) begin
          void'(exp_q.pop_front());
          pops++;
        end
      end else if (!bus.out_valid) begin
        chk("idle_out_pos", int'(bus.out_pos), 0);
        chk("idle_out_last", int'(bus.out_last), 0);
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic do_load(input logic [0:31] vec, input logic [4:0] start);
    bit acc = 1'b0;
    bit rdy;
    bus.load_valid = 1'b1;
    bus.load_vec   = vec;
    bus.load_start = start;
    for (int i = 0; i < 500 && !acc; i++) begin
      @(negedge clk);
      rdy = bus.load_ready;
      @(posedge clk);
      #1;
      if (rdy) acc = 1'b1;
    end
    bus.load_valid = 1'b0;
    if (!acc) begin
      chk("load_accept_timeout", 0, 1);
    end else begin
      push_model(vec, int'(start));
      exp_zero = (vec == '0);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic run5(input logic [0:4] vec, input logic [2:0] start, input int e0, input int e1);
    bus5.load_valid = 1'b1;
    bus5.load_vec   = vec;
    bus5.load_start = start;
    @(negedge clk);
    chk("n5_load_ready", int'(bus5.load_ready), 1);
    @(posedge clk);
    #1;
    bus5.load_valid = 1'b0;
    @(negedge clk);
    chk("n5_valid0", int'(bus5.out_valid), 1);
    chk("n5_pos0", int'(bus5.out_pos), e0);
    chk("n5_last0", int'(bus5.out_last), 0);
    @(negedge clk);
    chk("n5_valid1", int'(bus5.out_valid), 1);
    chk("n5_pos1", int'(bus5.out_pos), e1);
    chk("n5_last1", int'(bus5.out_last), 1);
    @(negedge clk);
    chk("n5_done_valid", int'(bus5.out_valid), 0);
    chk("n5_done_busy", int'(bus5.busy), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:31] v;
    int          p0;
    bus.load_valid  = 1'b0;
    bus.load_vec    = '0;
    bus.load_start  = '0;
    bus.out_ready   = 1'b1;
    bus5.load_valid = 1'b0;
    bus5.load_vec   = '0;
    bus5.load_start = '0;
    bus5.out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Bits 0 and 31, ready held high.
    rdy_mode = 0;
    do_load(32'h8000_0001, 5'd0);
    wait_drain();

    // Bits 3, 10, 20 from 15: 20, 3, 10.
    v = '0;
    v[3] = 1'b1;
    v[10] = 1'b1;
    v[20] = 1'b1;
    do_load(v, 5'd15);
    wait_drain();

    // All-zero load.
    do_load(32'h0, 5'd7);
    wait_drain();

    // Indices 0..7 from 6 with ready toggling: 6, 7, 0..5, each stalled once.
    rdy_mode = 1;
    p0 = pops;
    do_load(32'hFF00_0000, 5'd6);
    wait_drain();
    chk("toggle_accepts", pops - p0, 8);

    // Reset after three accepts, then a fresh single-bit load.
    rdy_mode = 0;
    bus.out_ready = 1'b1;
    p0 = pops;
    do_load(32'hFFFF_FFFF, 5'd0);
    for (int i = 0; i < 100 && pops < p0 + 3; i++) begin
      @(posedge clk);
      #1;
    end
    chk("pre_reset_accepts", pops - p0, 3);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    do_load(32'h0000_0100, 5'd0);
    wait_drain();

    // Randomized loads with random backpressure; some loads arrive while busy.
    rdy_mode = 2;
    for (int t = 0; t < 40; t++) begin
      case ($urandom % 4)
        0:       v = '0;
        1:       v = $urandom;
        2:       v = $urandom & $urandom & $urandom;
        default: v = 32'h1 << ($urandom % 32);
      endcase
      do_load(v, 5'($urandom % 32));
      if ($urandom % 2 == 0) wait_drain();
    end
    wait_drain();

    // Non-power-of-two width, including an out-of-range start.
    run5(5'b00011, 3'd4, 4, 3);
    run5(5'b00011, 3'd7, 3, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ffo_scan_iter.md
Name: ffo_scan_iter

Overview:
Parametrised, sequential successor to the combinational find-first-one block. It accepts an N-bit request vector and a start index, then emits the position of every set bit one per cycle over a valid/ready handshake. Emission is in circular priority order, beginning at the start index and wrapping past N-1 to 0. It sits between request-collection logic and a per-request consumer, such as an arbiter grant sequencer or an interrupt dispatcher.

Parameters:
N, 32, vector width; any integer >= 2 (not restricted to powers of two).
P, $clog2(N), position width; derived localparam, not overridable.

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high
load_valid  input  1  load request
load_ready  output  1  block can accept a load
load_vec  input  [0:N-1]  request vector; index 0 is leftmost/first
load_start  input  [0:P-1]  circular scan start index
out_valid  output  1  out_pos holds a valid position
out_ready  input  1  consumer accepts out_pos
out_pos  output  [0:P-1]  position of current first set bit
out_last  output  1  current out_pos is the final set bit of this load
zero_load  output  1  one-cycle pulse: accepted load_vec was all zeros
busy  output  1  scan in progress (state SCAN)

Behaviour:
- Registers: state {IDLE, SCAN}, mask[0:N-1], ptr[0:P-1], zero_load flop.
- Reset (sync, while reset=1):
  - state=IDLE, mask=0, ptr=0, zero_load=0.
  - Outputs during and after reset: out_valid=0, out_pos=0, out_last=0, busy=0.
  - load_ready = (state==IDLE) && !reset, so it is 0 while reset is high.
- IDLE:
  - load_ready=1.
  - Load is accepted when load_valid && load_ready.
  - Nonzero load_vec: mask<=load_vec, ptr<=load_start (a value >= N loads as 0), next state SCAN.
  - All-zero load_vec: stay IDLE, zero_load=1 on the next cycle only, mask unchanged.
- SCAN:
  - load_ready=0; load_valid is ignored.
  - busy=1, out_valid=1.
  - out_pos = lowest index i >= ptr with mask[i]=1; if none, lowest index i < ptr with mask[i]=1.
  - out_pos is computed combinationally from registered mask/ptr.
  - out_last=1 iff popcount(mask)==1.
- Handshake:
  - On out_valid && out_ready: mask[out_pos]<=0 and ptr<=(out_pos+1) mod N.
  - If out_last=1, the next state is IDLE.
- Stall: while out_valid && !out_ready, out_pos and out_last hold stable (mask and ptr unchanged).
- Latency: load accepted on edge k gives out_valid=1 after edge k; first position is available the cycle after load.
- Throughput: one position per cycle with out_ready tied high. A load with K set bits occupies K cycles of SCAN, then returns to IDLE, where load_ready=1 the following cycle (no back-to-back load/emit overlap).
- When out_valid=0, out_pos and out_last are driven 0 (never X).
- Wrap-around: ptr computed from out_pos=N-1 becomes 0. Non-power-of-two N must never produce ptr >= N.
- Reset mid-scan: abandons remaining bits, returns to IDLE with mask=0; no output is emitted for the remaining bits.
- X on load_vec bits beyond the first set bit at or after load_start must not corrupt the first out_pos (matches the find-first-one don't-care rule).

Test Plan:
- N=32, load_vec=32'h8000_0001 (bits 0 and 31 set), load_start=0, out_ready=1 -> out_pos=0 (out_last=0), then 31 (out_last=1); busy low on the following cycle.
- N=32, load_vec with bits 3, 10, 20 set, load_start=15 -> out_pos sequence 20, 3, 10; out_last on 10; ptr wraps correctly.
- N=32, load_vec=0 -> no out_valid, zero_load pulses exactly one cycle, load_ready stays 1.
- N=8, load_vec=8'hFF, load_start=6, out_ready toggling 1/0 each cycle -> out_pos 6, 7, 0, 1, 2, 3, 4, 5, each held stable across its stall cycle; exactly 8 accepts.
- N=32, all bits set, reset asserted after 3 accepts -> out_valid=0 next cycle, mask=0; a new load of 32'h0000_0100 yields out_pos=23 with out_last=1.
- N=5 (non-power-of-two), load_vec=5'b00011 (bits 3 and 4 set), load_start=4 -> out_pos 4, then 3; load_start=7 is treated as 0 -> out_pos 3, 4.
